// File: rtl/change_dispenser_pkg.sv
// Shared coin values, FSM encodings and greedy coin selection for the change dispenser.
package change_dispenser_pkg;
  localparam int QU_V = 5;
  localparam int DI_V = 2;
  localparam int NI_V = 1;

  typedef enum logic [1:0] {IDLE, PAY, GAP, DONE} state_t;
  typedef enum logic [1:0] {C_NONE, C_QU, C_DI, C_NI} coin_t;

  // Largest coin that fits the remainder and is in stock; C_NONE ends the payout.
  function automatic coin_t pick_coin(input logic [31:0] rem, input logic q, input logic d,
                                      input logic n);
    if (rem >= QU_V && q)      return C_QU;
    else if (rem >= DI_V && d) return C_DI;
    else if (rem >= NI_V && n) return C_NI;
    else                       return C_NONE;
  endfunction

  function automatic int coin_val(input coin_t c);
    case (c)
      C_QU:    return QU_V;
      C_DI:    return DI_V;
      C_NI:    return NI_V;
      default: return 0;
    endcase
  endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// Request/status/eject bundle between the vending FSM side and the change dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 6,
  parameter int INV_W = 6
);
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             refill;
  logic             busy;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] owed;
  logic             qu_out;
  logic             di_out;
  logic             ni_out;
  logic [INV_W-1:0] qu_cnt;
  logic [INV_W-1:0] di_cnt;
  logic [INV_W-1:0] ni_cnt;

  modport master (output req, amount, refill,
                  input  busy, done, short, owed, qu_out, di_out, ni_out, qu_cnt, di_cnt, ni_cnt);
  modport slave  (input  req, amount, refill,
                  output busy, done, short, owed, qu_out, di_out, ni_out, qu_cnt, di_cnt, ni_cnt);
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// Coin inventory: three counters with per-coin decrement, refill load and reset to the initial load.
module change_dispenser_coin_inventory #(
  parameter int INV_W   = 6,
  parameter int INIT_QU = 20,
  parameter int INIT_DI = 20,
  parameter int INIT_NI = 20
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             refill,
  input  logic             dec_qu,
  input  logic             dec_di,
  input  logic             dec_ni,
  output logic [INV_W-1:0] qu_cnt,
  output logic [INV_W-1:0] di_cnt,
  output logic [INV_W-1:0] ni_cnt
);
  always_ff @(posedge CLK) begin
    if (rst || refill) begin
      qu_cnt <= INV_W'(INIT_QU);
      di_cnt <= INV_W'(INIT_DI);
      ni_cnt <= INV_W'(INIT_NI);
    end else begin
      // Zero guards keep an empty tube from wrapping even if a stray decrement arrives.
      if (dec_qu && qu_cnt != '0) qu_cnt <= qu_cnt - 1'b1;
      if (dec_di && di_cnt != '0) di_cnt <= di_cnt - 1'b1;
      if (dec_ni && ni_cnt != '0) ni_cnt <= ni_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: greedy largest-coin-first payout FSM with forced gaps between eject pulses.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W   = 6,
  parameter int INV_W   = 6,
  parameter int INIT_QU = 20,
  parameter int INIT_DI = 20,
  parameter int INIT_NI = 20,
  parameter int GAP_CYC = 1
) (
  input logic CLK,
  input logic rst,
  change_dispenser_if.slave bus
);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t           state;
  logic [AMT_W-1:0] rem;
  logic [GW-1:0]    gcnt;
  coin_t            pick;
  logic             dec_qu, dec_di, dec_ni, refill_en;

  always_comb begin
    pick      = pick_coin(32'(rem), bus.qu_cnt != '0, bus.di_cnt != '0, bus.ni_cnt != '0);
    dec_qu    = (state == PAY) && (pick == C_QU);
    dec_di    = (state == PAY) && (pick == C_DI);
    dec_ni    = (state == PAY) && (pick == C_NI);
    refill_en = (state == IDLE) && bus.refill && !bus.req;
  end

  change_dispenser_coin_inventory #(
    .INV_W(INV_W), .INIT_QU(INIT_QU), .INIT_DI(INIT_DI), .INIT_NI(INIT_NI)
  ) u_inv (
    .CLK(CLK), .rst(rst), .refill(refill_en),
    .dec_qu(dec_qu), .dec_di(dec_di), .dec_ni(dec_ni),
    .qu_cnt(bus.qu_cnt), .di_cnt(bus.di_cnt), .ni_cnt(bus.ni_cnt)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      gcnt       <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.short  <= 1'b0;
      bus.owed   <= '0;
      bus.qu_out <= 1'b0;
      bus.di_out <= 1'b0;
      bus.ni_out <= 1'b0;
    end else begin
      bus.done   <= 1'b0;
      bus.short  <= 1'b0;
      bus.qu_out <= 1'b0;
      bus.di_out <= 1'b0;
      bus.ni_out <= 1'b0;
      case (state)
        IDLE: if (bus.req) begin
          rem      <= bus.amount;
          state    <= PAY;
          bus.busy <= 1'b1;
        end
        // A PAY with nothing payable (rem==0 or stock exhausted) closes the payout.
        PAY: if (pick == C_NONE) begin
          state     <= DONE;
          bus.done  <= 1'b1;
          bus.short <= (rem != '0);
          bus.owed  <= rem;
        end else begin
          rem        <= rem - AMT_W'(coin_val(pick));
          bus.qu_out <= (pick == C_QU);
          bus.di_out <= (pick == C_DI);
          bus.ni_out <= (pick == C_NI);
          gcnt       <= GW'(GAP_CYC - 1);
          state      <= GAP;
        end
        GAP: if (gcnt == '0) state <= PAY;
             else            gcnt  <= gcnt - 1'b1;
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a greedy reference model feeding coin/done scoreboards.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  change_dispenser_if #(.AMT_W(6), .INV_W(6)) bus ();

  change_dispenser #(
    .AMT_W(6), .INV_W(6), .INIT_QU(20), .INIT_DI(20), .INIT_NI(20), .GAP_CYC(1)
  ) dut (.CLK(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference inventory and expected outputs
  int mq = 20, md = 20, mn = 20;
  int coin_q[$];
  int short_q[$];
  int owed_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Scoreboard side: every pulse and every done is popped against the model.
  always @(negedge clk) begin
    if (!rst) begin
      int npulse;
      int coin;
      npulse = int'(bus.qu_out) + int'(bus.di_out) + int'(bus.ni_out);
      coin   = bus.qu_out ? 5 : bus.di_out ? 2 : bus.ni_out ? 1 : 0;
      if (npulse > 1) chk("one_pulse", npulse, 1);
      if (npulse != 0) begin
        if (coin_q.size() == 0) chk("unexpected_coin", coin, 0);
        else chk("coin", coin, coin_q.pop_front());
      end
      if (bus.done === 1'b1) begin
        if (short_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("short", int'(bus.short), short_q.pop_front());
          chk("owed", int'(bus.owed), owed_q.pop_front());
        end
      end
    end
  end

  task automatic push_model(input int amt);
    int r;
    r = amt;
    forever begin
      if (r >= 5 && mq > 0)      begin coin_q.push_back(5); r -= 5; mq--; end
      else if (r >= 2 && md > 0) begin coin_q.push_back(2); r -= 2; md--; end
      else if (r >= 1 && mn > 0) begin coin_q.push_back(1); r -= 1; mn--; end
      else break;
    end
    short_q.push_back(r != 0 ? 1 : 0);
    owed_q.push_back(r);
  endtask

  // Returns at the negedge of cycle E+1 (E = edge that sampled req).
  task automatic start_req(input int amt, input logic with_refill);
    @(negedge clk);
    bus.req    = 1'b1;
    bus.amount = 6'(amt);
    bus.refill = with_refill;
    @(negedge clk);
    bus.req    = 1'b0;
    bus.refill = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin seen = 1; break; end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic check_inv(input string tag);
    chk({tag, "_qu_cnt"}, int'(bus.qu_cnt), mq);
    chk({tag, "_di_cnt"}, int'(bus.di_cnt), md);
    chk({tag, "_ni_cnt"}, int'(bus.ni_cnt), mn);
  endtask

  task automatic finish_payout(input string tag);
    wait_done();
    @(negedge clk);
    chk({tag, "_busy_off"}, int'(bus.busy), 0);
    chk({tag, "_coins_left"}, coin_q.size(), 0);
    check_inv(tag);
  endtask

  task automatic pay(input string tag, input int amt);
    push_model(amt);
    start_req(amt, 1'b0);
    finish_payout(tag);
  endtask

  task automatic do_refill(input string tag);
    @(negedge clk);
    bus.refill = 1'b1;
    @(negedge clk);
    bus.refill = 1'b0;
    mq = 20; md = 20; mn = 20;
    check_inv(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.amount = '0; bus.refill = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_short", int'(bus.short), 0);
    chk("rst_owed", int'(bus.owed), 0);
    chk("rst_pulses", int'({bus.qu_out, bus.di_out, bus.ni_out}), 0);
    check_inv("rst");

    // 40c with full stock: exact cycle placement of pulses, done and busy.
    push_model(8);
    start_req(8, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("t1_qu_c%0d", c), int'(bus.qu_out), c == 2 ? 1 : 0);
      chk($sformatf("t1_di_c%0d", c), int'(bus.di_out), c == 4 ? 1 : 0);
      chk($sformatf("t1_ni_c%0d", c), int'(bus.ni_out), c == 6 ? 1 : 0);
      chk($sformatf("t1_done_c%0d", c), int'(bus.done), c == 8 ? 1 : 0);
      chk($sformatf("t1_busy_c%0d", c), int'(bus.busy), c <= 8 ? 1 : 0);
    end
    check_inv("t1");

    // Zero amount: done in cycle 2, no coins.
    push_model(0);
    start_req(0, 1'b0);
    @(negedge clk);
    chk("t2_done_c2", int'(bus.done), 1);
    chk("t2_owed", int'(bus.owed), 0);
    @(negedge clk);
    chk("t2_busy_off", int'(bus.busy), 0);

    // Drain quarters, then 25c must go out as dime, dime, nickel.
    do_refill("t3_refill");
    for (int k = 0; k < 4; k++) pay($sformatf("t3_drain%0d", k), 25);
    chk("t3_qu_empty", int'(bus.qu_cnt), 0);
    pay("t3_pay5", 5);

    // Drain dimes and all but one nickel, then 15c with only one nickel.
    pay("t4_drain_di", 36);
    pay("t4_drain_ni", 18);
    chk("t4_ni_one", int'(bus.ni_cnt), 1);
    pay("t4_short", 3);
    chk("t4_ni_zero", int'(bus.ni_cnt), 0);

    // Reset mid-payout: the first quarter is out, then everything stops and reloads.
    do_refill("t5_refill");
    coin_q.push_back(5);
    start_req(8, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    coin_q.delete();
    mq = 20; md = 20; mn = 20;
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_done", int'(bus.done), 0);
    check_inv("t5_reload");
    repeat (4) @(negedge clk);
    chk("t5_no_pulse", int'({bus.qu_out, bus.di_out, bus.ni_out}), 0);
    pay("t5_after", 8);

    // req and refill while busy are ignored.
    push_model(8);
    start_req(8, 1'b0);
    bus.req = 1'b1; bus.amount = 6'd1; bus.refill = 1'b1;
    @(negedge clk);
    bus.req = 1'b0; bus.refill = 1'b0;
    chk("t6_still_busy", int'(bus.busy), 1);
    finish_payout("t6_ignored");

    // req with refill in IDLE: req wins, refill dropped.
    push_model(1);
    start_req(1, 1'b1);
    finish_payout("t6_req_wins");
    do_refill("t6_refill");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
